// File: rtl/clock_pkg.sv
// clock_pkg: time_data field layout, set_mode encodings, BCD limits and helpers
package clock_pkg;

    localparam int TIME_W    = 20;
    localparam int SEC_U_LSB = 0;
    localparam int SEC_T_LSB = 4;
    localparam int MIN_U_LSB = 7;
    localparam int MIN_T_LSB = 11;
    localparam int HR_U_LSB  = 14;
    localparam int HR_T_LSB  = 18;

    localparam logic [7:0] LIM_MS = 8'h59;
    localparam logic [7:0] LIM_HR = 8'h23;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } set_mode_e;

    // Each field is a two-digit BCD byte: [7:4] tens, [3:0] units.
    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
    } bcd_time_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [TIME_W-1:0] pack_time(input bcd_time_t t);
        logic [TIME_W-1:0] w;
        w = '0;
        w[SEC_U_LSB +: 4] = t.sec[3:0];
        w[SEC_T_LSB +: 3] = t.sec[6:4];
        w[MIN_U_LSB +: 4] = t.min[3:0];
        w[MIN_T_LSB +: 3] = t.min[6:4];
        w[HR_U_LSB  +: 4] = t.hr[3:0];
        w[HR_T_LSB  +: 2] = t.hr[5:4];
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debounce and one-cycle press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk_sys,
    input  logic rstn,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_q;
    logic          r_pulse;
    logic          w_diff;

    assign w_diff  = r_sync[1] != r_level;
    assign o_pulse = r_pulse;

    // The level flips on the DEB_CYCLES-th consecutive differing sample; any equal sample restarts the run.
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_cnt     <= (w_diff && r_cnt != CNT_LAST) ? r_cnt + 1'b1 : '0;
            r_level   <= (w_diff && r_cnt == CNT_LAST) ? r_sync[1] : r_level;
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD hh:mm:ss clock with two-button hour/minute setting
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic              clk_sys,
    input  logic              rstn,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [TIME_W-1:0] time_data,
    output logic [1:0]        set_mode,
    output logic              sec_pulse
);

    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

    set_mode_e     r_state;
    set_mode_e     w_state_nxt;
    logic [PW-1:0] r_presc;
    bcd_time_t     r_time;
    bcd_time_t     w_time_nxt;
    logic          w_mode_p;
    logic          w_inc_p;
    logic          w_tick;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
        .clk_sys (clk_sys),
        .rstn    (rstn),
        .i_btn   (btn_mode),
        .o_pulse (w_mode_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
        .clk_sys (clk_sys),
        .rstn    (rstn),
        .i_btn   (btn_inc),
        .o_pulse (w_inc_p)
    );

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn)
            r_state <= MODE_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_p) begin
            unique case (r_state)
                MODE_RUN:      w_state_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: w_state_nxt = MODE_SET_MIN;
                default:       w_state_nxt = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        set_mode  = r_state;
        w_tick    = (r_state == MODE_RUN) && (r_presc == PRESC_TC);
        sec_pulse = w_tick;
    end

    // Held at zero outside RUN, so the first tick after leaving SET_MIN is a full second away.
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn)
            r_presc <= '0;
        else
            r_presc <= (r_state != MODE_RUN || w_tick) ? '0 : r_presc + 1'b1;
    end

    // A tick beats a coincident mode press; mode beats a coincident inc press.
    always_comb begin
        w_time_nxt = r_time;
        if (w_tick) begin
            w_time_nxt.sec = bcd_inc(r_time.sec, LIM_MS);
            if (r_time.sec == LIM_MS) begin
                w_time_nxt.min = bcd_inc(r_time.min, LIM_MS);
                if (r_time.min == LIM_MS)
                    w_time_nxt.hr = bcd_inc(r_time.hr, LIM_HR);
            end
        end else if (w_mode_p) begin
            if (r_state == MODE_SET_MIN)
                w_time_nxt.sec = 8'h00;
        end else if (w_inc_p) begin
            if (r_state == MODE_SET_HOUR)
                w_time_nxt.hr = bcd_inc(r_time.hr, LIM_HR);
            else if (r_state == MODE_SET_MIN)
                w_time_nxt.min = bcd_inc(r_time.min, LIM_MS);
        end
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn)
            r_time <= '0;
        else
            r_time <= w_time_nxt;
    end

    assign time_data = pack_time(r_time);

endmodule
